// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Define PIPELINED_CLA_ADDER_FLAGS_EN to add registered ovf/zero result flags.
module pipelined_cla_adder #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_i,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_o
`ifdef PIPELINED_CLA_ADDER_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);
    localparam int H = WIDTH / 2;

    // Carries inside each 4-bit group come from prefix generate/propagate and the group carry-in.
    function automatic logic [H:0] cla_add(input logic [H-1:0] x, input logic [H-1:0] y,
                                           input logic cin);
        logic [H-1:0] p;
        logic [H-1:0] g;
        logic [H:0]   c;
        logic         gg;
        logic         gp;
        p    = x | y;
        g    = x & y;
        c    = '0;
        c[0] = cin;
        for (int base = 0; base < H; base += 4) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (base + k < H) begin
                    gg             = g[base+k] | (p[base+k] & gg);
                    gp             = gp & p[base+k];
                    c[base+k+1]    = gg | (gp & c[base]);
                end
            end
        end
        return {c[H], (p & ~g) ^ c[H-1:0]};
    endfunction

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [H:0]       lo_sum;
    logic [H:0]       hi_sum;
    logic             out_adv;
    logic             in_fire;

    logic             s1_valid_q, s1_valid_d;
    logic [H-1:0]     s1_sum_lo_q, s1_sum_lo_d;
    logic             s1_c_q, s1_c_d;
    logic [H-1:0]     s1_a_hi_q, s1_a_hi_d;
    logic [H-1:0]     s1_b_hi_q, s1_b_hi_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_o_q, c_o_d;

    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : c_i;
    assign lo_sum  = cla_add(a[H-1:0], b_eff[H-1:0], cin_eff);
    assign hi_sum  = cla_add(s1_a_hi_q, s1_b_hi_q, s1_c_q);

    assign out_adv  = !out_valid_q || out_ready;
    assign in_ready = !reset && (!s1_valid_q || out_adv);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sum_lo_d = s1_sum_lo_q;
        s1_c_d      = s1_c_q;
        s1_a_hi_d   = s1_a_hi_q;
        s1_b_hi_d   = s1_b_hi_q;
        out_valid_d = out_valid_q;
        s_d         = s_q;
        c_o_d       = c_o_q;
        if (in_fire) begin
            s1_valid_d  = 1'b1;
            s1_sum_lo_d = lo_sum[H-1:0];
            s1_c_d      = lo_sum[H];
            s1_a_hi_d   = a[WIDTH-1:H];
            s1_b_hi_d   = b_eff[WIDTH-1:H];
        end else if (s1_valid_q && out_adv) begin
            s1_valid_d = 1'b0;
        end
        // The output register is refilled whenever it is free or being drained this cycle.
        if (out_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s_d   = {hi_sum[H-1:0], s1_sum_lo_q};
                c_o_d = hi_sum[H];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sum_lo_q <= '0;
            s1_c_q      <= 1'b0;
            s1_a_hi_q   <= '0;
            s1_b_hi_q   <= '0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            c_o_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_lo_q <= s1_sum_lo_d;
            s1_c_q      <= s1_c_d;
            s1_a_hi_q   <= s1_a_hi_d;
            s1_b_hi_q   <= s1_b_hi_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            c_o_q       <= c_o_d;
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign c_o       = c_o_q;

`ifdef PIPELINED_CLA_ADDER_FLAGS_EN
    logic ovf_q, ovf_d;
    logic zero_q, zero_d;

    always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (out_adv && s1_valid_q) begin
            ovf_d  = (s1_a_hi_q[H-1] == s1_b_hi_q[H-1]) && (hi_sum[H-1] != s1_a_hi_q[H-1]);
            zero_d = ({hi_sum[H-1:0], s1_sum_lo_q} == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`endif

endmodule
